vend_txn_ctrl: RTL and testbench
================================

# vend_txn_ctrl

Transaction controller for the cola vending machine. It accumulates debounced coin pulses into a credit and decides when to dispense. It sequences the dispense mechanism and the change/refund coin hopper over req/ack handshakes, and drives a display-mode code for the LED pattern block. It sits between the key debouncers and the dispense, hopper and LED datapaths.

## Interface
- PRICE_HALVES, 5: item price in 0.5-unit steps (2.5).
- TIMEOUT_CYC, 250_000_000: idle-credit timeout, 5 s at 50 MHz.
- ACK_TO_CYC, 50_000_000: maximum wait for any ack, 1 s.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- coin_half  in  1  one-cycle pulse, 0.5-unit coin.
- coin_one  in  1  one-cycle pulse, 1-unit coin.
- disp_req  out  1  dispense request, held until ack.
- disp_ack  in  1  one-cycle dispense-complete pulse.
- chg_req  out  1  return-one-0.5-coin request, held while credit > 0.
- chg_ack  in  1  one-cycle pulse, one 0.5 coin returned.
- credit  out  4  current credit in halves.
- led_mode  out  2  0 idle, 1 credit, 2 vending, 3 refund/fault.
- coin_rej  out  1  one-cycle pulse, coin arrived while not accepting.
- fault  out  1  sticky hopper/dispense failure.

## Operation
- States: IDLE, CREDIT, DISPENSE, CHANGE, REFUND, FAULT.
- **Coin value:** add = coin_half + 2·coin_one. A simultaneous pulse on both inputs adds 3.
- **Accepting states:** coins are added only in IDLE and CREDIT.
  - In any other state, each coin pulse produces a coin_rej pulse and credit is unchanged.
- **IDLE:** credit = 0. On add > 0:
  - go to CREDIT with credit = add,
  - or go to DISPENSE if add ≥ PRICE_HALVES.
- **CREDIT:**
  - Each coin adds to credit and restarts the timeout counter.
  - When the new credit ≥ PRICE_HALVES: go to DISPENSE, with credit = new credit − PRICE_HALVES.
  - Maximum credit is PRICE_HALVES+2. The 4-bit credit never overflows for PRICE_HALVES ≤ 13.
  - Timeout counter reaches TIMEOUT_CYC−1 with no coin: go to REFUND.
  - A coin arriving in the expiry cycle wins: it is added, and there is no refund.
- **DISPENSE:**
  - disp_req = 1.
  - On disp_ack: go to CHANGE if credit > 0, else IDLE.
  - No ack within ACK_TO_CYC: credit += PRICE_HALVES, go to REFUND.
- **CHANGE and REFUND:**
  - chg_req = 1.
  - Each chg_ack decrements credit by 1.
  - The ack that brings credit to 0 sends the machine to IDLE.
  - The wait counter restarts on every ack. No ack within ACK_TO_CYC: go to FAULT.
- **FAULT:** all requests 0, fault = 1, led_mode = 3, coins rejected. Only reset exits.
- **Stray acks:** an ack arriving while its req is low is ignored.
- **led_mode by state:** IDLE 0; CREDIT 1; DISPENSE and CHANGE 2; REFUND and FAULT 3.

## Timing
- **Reset values:** state IDLE; credit 0; disp_req, chg_req, coin_rej, fault all 0; led_mode 0; both counters 0.
- **Reset mid-transaction:** drops requests immediately and discards credit.
- **Output registration:** all outputs are registered and updated together from the next-state values.
  - A coin at edge n gives new credit, state, disp_req and led_mode at edge n+1.
- **Request release:** disp_req falls in the cycle after disp_ack. chg_req falls in the cycle after the final chg_ack.
- **Ack throughput:** back-to-back chg_ack pulses on consecutive cycles are each counted, one coin per cycle.
- **Timeout counters:** wait exactly TIMEOUT_CYC or ACK_TO_CYC cycles from entering or restarting before the transition fires. Their widths derive from $clog2 of the parameter.

## Structure
- **Package vend_pkg:** state enum, led_mode codes (LED_IDLE, LED_CREDIT, LED_VEND, LED_REFUND), credit width constant.
- **Sub-module vend_timer:** one parameterised countdown with clear/enable/expire ports. It is instantiated twice, for the credit timeout and the ack timeout.
- **Top-level contents:** the FSM and credit arithmetic only.

## Test plan
- **Exact price:** PRICE_HALVES=5; pulses coin_one, coin_one, coin_half → DISPENSE with credit 0; disp_ack → IDLE, chg_req never rises.
- **Overpay:** coin_one ×3 → DISPENSE with credit 1; disp_ack → CHANGE; one chg_ack → credit 0, IDLE.
- **Credit timeout:** TIMEOUT_CYC=100; coin_one, then no coins for 100 cycles → REFUND, led_mode 3; two chg_acks → IDLE.
- **Simultaneous and rejected coins:** coin_half and coin_one in the same cycle → credit 3. A coin in DISPENSE → coin_rej pulse, credit unchanged.
- **Dispense timeout:** ACK_TO_CYC=50; reach DISPENSE with credit 1, no disp_ack → REFUND with credit 6; six chg_acks → IDLE.
- **Hopper fault and reset:** in REFUND, withhold chg_ack for 50 cycles → fault = 1, all requests 0; rst_n low → all outputs back to reset values.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and constants for the cola vending transaction controller.
package vend_pkg;

  localparam int unsigned CREDIT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CREDIT,
    ST_DISPENSE,
    ST_CHANGE,
    ST_REFUND,
    ST_FAULT
  } vend_state_e;

  typedef enum logic [1:0] {
    LED_IDLE   = 2'd0,
    LED_CREDIT = 2'd1,
    LED_VEND   = 2'd2,
    LED_REFUND = 2'd3
  } led_mode_e;

  // LED pattern selected by each controller state.
  function automatic led_mode_e led_for_state(vend_state_e st);
    led_mode_e mode;
    mode = LED_IDLE;
    case (st)
      ST_IDLE:                 mode = LED_IDLE;
      ST_CREDIT:               mode = LED_CREDIT;
      ST_DISPENSE, ST_CHANGE:  mode = LED_VEND;
      ST_REFUND, ST_FAULT:     mode = LED_REFUND;
      default:                 mode = LED_REFUND;
    endcase
    return mode;
  endfunction

endpackage

// File: rtl/vend_timer.sv
// Up-counting timeout: expire_c asserts in the CYC-th enabled cycle after clear.
module vend_timer #(
  parameter int unsigned CYC = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire_c
);

  localparam int unsigned CNT_W = (CYC > 1) ? $clog2(CYC) : 1;

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign expire_c = en && (count_q == CNT_W'(CYC - 1));

endmodule

// File: rtl/vend_txn_ctrl.sv
// Vending transaction FSM: coin credit, dispense and change/refund handshakes.
module vend_txn_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned PRICE_HALVES = 5,
  parameter int unsigned TIMEOUT_CYC  = 250_000_000,
  parameter int unsigned ACK_TO_CYC   = 50_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin_half,
  input  logic                coin_one,
  output logic                disp_req,
  input  logic                disp_ack,
  output logic                chg_req,
  input  logic                chg_ack,
  output logic [CREDIT_W-1:0] credit,
  output logic [1:0]          led_mode,
  output logic                coin_rej,
  output logic                fault
);

  localparam int unsigned SUM_W = CREDIT_W + 1;
  localparam logic [SUM_W-1:0] PRICE = SUM_W'(PRICE_HALVES);

  vend_state_e         state_q, state_d;
  logic [CREDIT_W-1:0] credit_d;
  logic [1:0]          add_c;
  logic [SUM_W-1:0]    sum_c;
  logic                accept_c;
  logic                disp_ack_v_c, chg_ack_v_c;
  logic                tmo_clr_c, tmo_en_c, tmo_expire_c;
  logic                ack_clr_c, ack_en_c, ack_expire_c;

  assign add_c        = {coin_one, 1'b0} + {1'b0, coin_half};
  assign sum_c        = SUM_W'(credit) + SUM_W'(add_c);
  assign accept_c     = (state_q == ST_IDLE) || (state_q == ST_CREDIT);
  // Acks only count while the matching request is asserted.
  assign disp_ack_v_c = disp_ack && (state_q == ST_DISPENSE);
  assign chg_ack_v_c  = chg_ack && ((state_q == ST_CHANGE) || (state_q == ST_REFUND));

  assign tmo_en_c  = (state_q == ST_CREDIT);
  assign tmo_clr_c = !tmo_en_c || (add_c != 2'd0);
  assign ack_en_c  = (state_q == ST_DISPENSE) || (state_q == ST_CHANGE) ||
                     (state_q == ST_REFUND);
  assign ack_clr_c = !ack_en_c || (state_d != state_q) || chg_ack_v_c;

  vend_timer #(.CYC(TIMEOUT_CYC)) u_credit_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (tmo_clr_c),
    .en       (tmo_en_c),
    .expire_c (tmo_expire_c)
  );

  vend_timer #(.CYC(ACK_TO_CYC)) u_ack_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (ack_clr_c),
    .en       (ack_en_c),
    .expire_c (ack_expire_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      credit   <= '0;
      disp_req <= 1'b0;
      chg_req  <= 1'b0;
      led_mode <= LED_IDLE;
      coin_rej <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit   <= credit_d;
      disp_req <= (state_d == ST_DISPENSE);
      chg_req  <= (state_d == ST_CHANGE) || (state_d == ST_REFUND);
      led_mode <= led_for_state(state_d);
      coin_rej <= (add_c != 2'd0) && !accept_c;
      fault    <= (state_d == ST_FAULT);
    end
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit;
    case (state_q)
      // A coin in the credit-expiry cycle takes priority over the refund.
      ST_IDLE, ST_CREDIT: begin
        if (add_c != 2'd0) begin
          if (sum_c >= PRICE) begin
            state_d  = ST_DISPENSE;
            credit_d = CREDIT_W'(sum_c - PRICE);
          end else begin
            state_d  = ST_CREDIT;
            credit_d = CREDIT_W'(sum_c);
          end
        end else if (tmo_expire_c) begin
          state_d = ST_REFUND;
        end
      end
      ST_DISPENSE: begin
        if (disp_ack_v_c) begin
          state_d = (credit != '0) ? ST_CHANGE : ST_IDLE;
        end else if (ack_expire_c) begin
          state_d  = ST_REFUND;
          credit_d = credit + CREDIT_W'(PRICE_HALVES);
        end
      end
      ST_CHANGE, ST_REFUND: begin
        if (chg_ack_v_c) begin
          credit_d = credit - CREDIT_W'(1);
          if (credit == CREDIT_W'(1)) begin
            state_d = ST_IDLE;
          end
        end else if (ack_expire_c) begin
          state_d = ST_FAULT;
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d  = ST_IDLE;
        credit_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// Directed and randomized bench for vend_txn_ctrl against a transaction-level model.
module tb_vend_txn_ctrl;

  localparam int unsigned P  = 5;
  localparam int unsigned TO = 100;
  localparam int unsigned AT = 50;

  // Model phases: 0 idle, 1 collecting, 2 vending, 3 giving change, 4 refunding, 5 broken
  localparam int PH_IDLE = 0, PH_COLL = 1, PH_VEND = 2, PH_CHG = 3, PH_REF = 4, PH_BRK = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       coin_half = 1'b0, coin_one = 1'b0, disp_ack = 1'b0, chg_ack = 1'b0;
  logic       disp_req, chg_req, coin_rej, fault;
  logic [3:0] credit;
  logic [1:0] led_mode;

  int checks = 0;
  int failures = 0;

  int m_phase, m_credit, m_waited;
  bit m_rej;
  int led_tab[6] = '{0, 1, 2, 2, 3, 3};

  always #5 clk = ~clk;

  vend_txn_ctrl #(
    .PRICE_HALVES (P),
    .TIMEOUT_CYC  (TO),
    .ACK_TO_CYC   (AT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .coin_half (coin_half),
    .coin_one  (coin_one),
    .disp_req  (disp_req),
    .disp_ack  (disp_ack),
    .chg_req   (chg_req),
    .chg_ack   (chg_ack),
    .credit    (credit),
    .led_mode  (led_mode),
    .coin_rej  (coin_rej),
    .fault     (fault)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = PH_IDLE; m_credit = 0; m_waited = 0; m_rej = 1'b0;
  endtask

  // One clock edge of the vending rules with the inputs present at that edge.
  task automatic model_step(input bit ch, input bit co, input bit da, input bit ca);
    int add;
    add = int'(ch) + 2 * int'(co);
    m_rej = (add > 0) && !(m_phase == PH_IDLE || m_phase == PH_COLL);
    if (m_phase == PH_IDLE || m_phase == PH_COLL) begin
      if (add > 0) begin
        m_credit += add;
        m_waited = 0;
        if (m_credit >= P) begin
          m_credit -= P;
          m_phase = PH_VEND;
        end else m_phase = PH_COLL;
      end else if (m_phase == PH_COLL) begin
        m_waited++;
        if (m_waited == TO) begin m_phase = PH_REF; m_waited = 0; end
      end
    end else if (m_phase == PH_VEND) begin
      if (da) begin
        m_phase = (m_credit > 0) ? PH_CHG : PH_IDLE;
        m_waited = 0;
      end else begin
        m_waited++;
        if (m_waited == AT) begin m_credit += P; m_phase = PH_REF; m_waited = 0; end
      end
    end else if (m_phase == PH_CHG || m_phase == PH_REF) begin
      if (ca) begin
        m_credit--;
        m_waited = 0;
        if (m_credit == 0) m_phase = PH_IDLE;
      end else begin
        m_waited++;
        if (m_waited == AT) m_phase = PH_BRK;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, ".credit"}, 32'(credit), 32'(m_credit));
    check_val({tag, ".led"}, 32'(led_mode), 32'(led_tab[m_phase]));
    check_val({tag, ".disp_req"}, 32'(disp_req), 32'(m_phase == PH_VEND));
    check_val({tag, ".chg_req"}, 32'(chg_req), 32'(m_phase == PH_CHG || m_phase == PH_REF));
    check_val({tag, ".coin_rej"}, 32'(coin_rej), 32'(m_rej));
    check_val({tag, ".fault"}, 32'(fault), 32'(m_phase == PH_BRK));
  endtask

  task automatic tick(input bit ch, input bit co, input bit da, input bit ca);
    coin_half = ch; coin_one = co; disp_ack = da; chg_ack = ca;
    @(posedge clk);
    model_step(ch, co, da, ca);
    #1;
    check_outputs("cyc");
    coin_half = 1'b0; coin_one = 1'b0; disp_ack = 1'b0; chg_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset asserted away from the clock edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int pcts[4] = '{0, 5, 30, 80};
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    check_val("reset_led", 32'(led_mode), 0);
    rst_n = 1'b1;

    // Exact price
    tick(0, 1, 0, 0); tick(0, 1, 0, 0); tick(1, 0, 0, 0);
    check_val("exact_disp_req", 32'(disp_req), 1);
    check_val("exact_credit", 32'(credit), 0);
    check_val("exact_led", 32'(led_mode), 2);
    idle(3);
    tick(0, 0, 1, 0);
    check_val("exact_done_led", 32'(led_mode), 0);
    check_val("exact_no_chg", 32'(chg_req), 0);

    // Overpay
    repeat (3) tick(0, 1, 0, 0);
    check_val("over_credit", 32'(credit), 1);
    tick(0, 0, 1, 0);
    check_val("over_chg_req", 32'(chg_req), 1);
    check_val("over_disp_rel", 32'(disp_req), 0);
    tick(0, 0, 0, 1);
    check_val("over_credit0", 32'(credit), 0);
    check_val("over_chg_rel", 32'(chg_req), 0);

    // Simultaneous and rejected coins
    tick(1, 1, 0, 0);
    check_val("simul_credit", 32'(credit), 3);
    tick(0, 1, 0, 0);
    tick(1, 0, 0, 0);
    check_val("rej_pulse", 32'(coin_rej), 1);
    check_val("rej_credit", 32'(credit), 0);
    idle(1);
    check_val("rej_clear", 32'(coin_rej), 0);
    tick(0, 0, 1, 0);

    // Credit timeout boundary and stray acks
    tick(0, 1, 0, 0);
    idle(TO - 1);
    check_val("tmo_pre_led", 32'(led_mode), 1);
    idle(1);
    check_val("tmo_led", 32'(led_mode), 3);
    check_val("tmo_chg_req", 32'(chg_req), 1);
    tick(0, 0, 0, 1); tick(0, 0, 0, 1);
    check_val("tmo_done_led", 32'(led_mode), 0);
    tick(0, 0, 1, 1);
    check_val("stray_led", 32'(led_mode), 0);

    // Coin in the expiry cycle wins
    tick(1, 0, 0, 0);
    idle(TO - 1);
    tick(1, 0, 0, 0);
    check_val("expiry_coin_credit", 32'(credit), 2);
    check_val("expiry_coin_led", 32'(led_mode), 1);
    idle(TO);
    tick(0, 0, 0, 1); tick(0, 0, 0, 1);

    // Dispense timeout
    repeat (3) tick(0, 1, 0, 0);
    idle(AT - 1);
    check_val("dto_pre_disp", 32'(disp_req), 1);
    idle(1);
    check_val("dto_credit", 32'(credit), 6);
    check_val("dto_led", 32'(led_mode), 3);
    repeat (6) tick(0, 0, 0, 1);
    check_val("dto_done_credit", 32'(credit), 0);
    check_val("dto_done_led", 32'(led_mode), 0);

    // Hopper fault, then reset
    tick(0, 1, 0, 0);
    idle(TO);
    idle(AT - 1);
    check_val("flt_pre", 32'(fault), 0);
    idle(1);
    check_val("flt_fault", 32'(fault), 1);
    check_val("flt_chg_req", 32'(chg_req), 0);
    check_val("flt_disp_req", 32'(disp_req), 0);
    tick(0, 1, 0, 0);
    check_val("flt_rej", 32'(coin_rej), 1);
    check_val("flt_credit", 32'(credit), 2);
    do_reset();
    check_val("flt_rst_fault", 32'(fault), 0);
    check_val("flt_rst_credit", 32'(credit), 0);

    // Reset mid-transaction
    repeat (3) tick(0, 1, 0, 0);
    do_reset();
    check_val("mid_rst_disp", 32'(disp_req), 0);

    // Randomized traffic with varying ack responsiveness
    for (int seg = 0; seg < 40; seg++) begin
      int pct;
      pct = pcts[seg % 4];
      repeat (100) begin
        bit ch, co, da, ca;
        ch = ($urandom_range(0, 9) == 0);
        co = ($urandom_range(0, 9) == 0);
        if (m_phase == PH_VEND) da = ($urandom_range(0, 99) < pct);
        else da = ($urandom_range(0, 39) == 0);
        if (m_phase == PH_CHG || m_phase == PH_REF) ca = ($urandom_range(0, 99) < pct);
        else ca = ($urandom_range(0, 39) == 0);
        tick(ch, co, da, ca);
        if (m_phase == PH_BRK || $urandom_range(0, 499) == 0) do_reset();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
